// File: rtl/fft_frame_sink_if.sv
// Stream-in / peak-out bundle for fft_frame_sink. The slave modport is the sink's view;
// the master modport is the view of whatever drives samples and consumes results.
interface fft_frame_sink_if #(
    parameter int IDX_W = 10
);
    logic [63:0]      s_axis_data_tdata;
    logic             s_axis_data_tvalid;
    logic             s_axis_data_tready;
    logic             s_axis_data_tlast;
    logic             peak_tvalid;
    logic             peak_tready;
    logic [IDX_W-1:0] peak_index;
    logic [32:0]      peak_mag;
    logic [IDX_W:0]   frame_count;
    logic             event_tlast_unexpected;
    logic             event_tlast_missing;

    modport slave (
        input  s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast, peak_tready,
        output s_axis_data_tready, peak_tvalid, peak_index, peak_mag, frame_count,
               event_tlast_unexpected, event_tlast_missing
    );

    modport master (
        output s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast, peak_tready,
        input  s_axis_data_tready, peak_tvalid, peak_index, peak_mag, frame_count,
               event_tlast_unexpected, event_tlast_missing
    );
endinterface

// File: rtl/fft_frame_sink.sv
// Consumes one FFT frame of complex samples and reports the bin with the largest |re|+|im|.
// Define FFT_SINK_SKIP_DC_EN to exclude bin 0 (DC) from the peak search.
module fft_frame_sink #(
    parameter int FRAME_LEN = 1024,
    parameter int IDX_W     = 10
) (
    input  logic              aclk,
    input  logic              areset,
    fft_frame_sink_if.slave   bus
);
    typedef enum logic {COLLECT = 1'b0, REPORT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] bin_q;
    logic [32:0]      run_mag_q;
    logic [IDX_W-1:0] run_idx_q;
    logic [32:0]      beat_mag;
    logic [32:0]      cand_mag;
    logic [IDX_W-1:0] cand_idx;
    logic             accept, last_bin, frame_end;

    // Sign-extend before negating so that -2^31 maps to +2^31 without saturation.
    function automatic logic [32:0] abs33(input logic [31:0] v);
        return v[31] ? (33'd0 - {1'b1, v}) : {1'b0, v};
    endfunction

    assign bus.s_axis_data_tready = (state_q == COLLECT) && !areset;
    assign bus.peak_tvalid        = (state_q == REPORT) && !areset;

    assign accept    = bus.s_axis_data_tvalid && bus.s_axis_data_tready;
    assign last_bin  = (bin_q == IDX_W'(FRAME_LEN - 1));
    assign frame_end = accept && (bus.s_axis_data_tlast || last_bin);
    assign beat_mag  = abs33(bus.s_axis_data_tdata[31:0]) + abs33(bus.s_axis_data_tdata[63:32]);

    // Running peak including the current beat; strict '>' keeps the lowest bin on ties.
    always_comb begin
        cand_mag = run_mag_q;
        cand_idx = run_idx_q;
`ifdef FFT_SINK_SKIP_DC_EN
        if (bin_q == '0) begin
            cand_mag = '0;
            cand_idx = '0;
        end else if (bin_q == IDX_W'(1) || beat_mag > run_mag_q) begin
            cand_mag = beat_mag;
            cand_idx = bin_q;
        end
`else
        if (bin_q == '0 || beat_mag > run_mag_q) begin
            cand_mag = beat_mag;
            cand_idx = bin_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (frame_end)       state_d = REPORT;
            REPORT:  if (bus.peak_tready) state_d = COLLECT;
            default:                      state_d = COLLECT;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) state_q <= COLLECT;
        else        state_q <= state_d;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            bin_q     <= '0;
            run_mag_q <= '0;
            run_idx_q <= '0;
        end else if (accept) begin
            bin_q     <= frame_end ? '0 : bin_q + IDX_W'(1);
            run_mag_q <= cand_mag;
            run_idx_q <= cand_idx;
        end
    end

    // Result registers only load on the ending beat, so they hold for the whole REPORT stall.
    always_ff @(posedge aclk) begin
        if (areset) begin
            bus.peak_index             <= '0;
            bus.peak_mag               <= '0;
            bus.frame_count            <= '0;
            bus.event_tlast_unexpected <= 1'b0;
            bus.event_tlast_missing    <= 1'b0;
        end else begin
            bus.event_tlast_unexpected <= frame_end && bus.s_axis_data_tlast && !last_bin;
            bus.event_tlast_missing    <= frame_end && last_bin && !bus.s_axis_data_tlast;
            if (frame_end) begin
                bus.peak_index  <= cand_idx;
                bus.peak_mag    <= cand_mag;
                bus.frame_count <= (IDX_W + 1)'(bin_q) + (IDX_W + 1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_sink.sv
// Directed bench for fft_frame_sink with FRAME_LEN=16: table of frames plus stall and reset sequences.
module tb_fft_frame_sink;
    localparam int FL = 16;
    localparam int IW = 4;

    typedef struct {
        string       name;
        int          ba;  logic [31:0] rea; logic [31:0] ima;
        int          bb;  logic [31:0] reb; logic [31:0] imb;
        int          eb;  bit          tl;
        int          eidx; logic [32:0] emag; int ecnt; int eun; int emi;
    } vec_t;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   n_un = 0;
    int   n_mi = 0;
    vec_t vt[8];

    fft_frame_sink_if #(.IDX_W(IW)) bus ();

    fft_frame_sink #(.FRAME_LEN(FL), .IDX_W(IW)) dut (
        .aclk(aclk), .areset(areset), .bus(bus)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (bus.event_tlast_unexpected) n_un++;
        if (bus.event_tlast_missing)    n_mi++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input int ba, input logic [31:0] rea,
                                input logic [31:0] ima, input int bb, input logic [31:0] reb,
                                input logic [31:0] imb, input int eb, input bit tl, input int eidx,
                                input logic [32:0] emag, input int ecnt, input int eun, input int emi);
        vec_t v;
        v.name = nm; v.ba = ba; v.rea = rea; v.ima = ima; v.bb = bb; v.reb = reb; v.imb = imb;
        v.eb = eb; v.tl = tl; v.eidx = eidx; v.emag = emag; v.ecnt = ecnt; v.eun = eun; v.emi = emi;
        return v;
    endfunction

    task automatic beat(input logic [31:0] re, input logic [31:0] im, input bit last);
        bus.s_axis_data_tdata  = {im, re};
        bus.s_axis_data_tvalid = 1'b1;
        bus.s_axis_data_tlast  = last;
        @(posedge aclk);
        #1;
        bus.s_axis_data_tvalid = 1'b0;
        bus.s_axis_data_tlast  = 1'b0;
    endtask

    task automatic send(input vec_t v);
        logic [31:0] re, im;
        for (int b = 0; b <= v.eb; b++) begin
            re = 32'd0; im = 32'd0;
            if (b == v.ba) begin re = v.rea; im = v.ima; end
            if (b == v.bb) begin re = v.reb; im = v.imb; end
            beat(re, im, v.tl && (b == v.eb));
        end
    endtask

    task automatic run_vec(input vec_t v);
        int un0, mi0;
        un0 = n_un; mi0 = n_mi;
        send(v);
        chk({v.name, " peak_tvalid"}, 64'(bus.peak_tvalid), 64'd1);
        chk({v.name, " peak_index"},  64'(bus.peak_index),  64'(v.eidx));
        chk({v.name, " peak_mag"},    64'(bus.peak_mag),    64'(v.emag));
        chk({v.name, " frame_count"}, 64'(bus.frame_count), 64'(v.ecnt));
        bus.peak_tready = 1'b1;
        @(posedge aclk);
        #1;
        bus.peak_tready = 1'b0;
        chk({v.name, " tready_after_hs"}, 64'(bus.s_axis_data_tready), 64'd1);
        chk({v.name, " tvalid_after_hs"}, 64'(bus.peak_tvalid), 64'd0);
        chk({v.name, " unexpected_pulses"}, 64'(n_un - un0), 64'(v.eun));
        chk({v.name, " missing_pulses"},    64'(n_mi - mi0), 64'(v.emi));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int saw;
        vt[0] = mk("single_peak", 5, 32'd100, -32'sd50, -1, 0, 0, 15, 1, 5, 33'd150, 16, 0, 0);
        vt[1] = mk("tie_low_bin", 3, 32'd200, 32'd0, 9, -32'sd100, 32'd100, 15, 1, 3, 33'd200, 16, 0, 0);
        vt[2] = mk("early_tlast", 2, 32'd7, 32'd7, -1, 0, 0, 7, 1, 2, 33'd14, 8, 1, 0);
        vt[3] = mk("missing_tlast", 10, -32'sd5, -32'sd6, -1, 0, 0, 15, 0, 10, 33'd11, 16, 0, 1);
`ifdef FFT_SINK_SKIP_DC_EN
        vt[4] = mk("dc_min_neg", 0, 32'h8000_0000, 32'd0, 12, 32'd3, 32'd7, 15, 1, 12, 33'd10, 16, 0, 0);
        vt[6] = mk("end_at_bin0", 0, 32'd1, 32'd1, -1, 0, 0, 0, 1, 0, 33'd0, 1, 1, 0);
`else
        vt[4] = mk("dc_min_neg", 0, 32'h8000_0000, 32'd0, 12, 32'd3, 32'd7, 15, 1, 0, 33'd2147483648, 16, 0, 0);
        vt[6] = mk("end_at_bin0", 0, 32'd1, 32'd1, -1, 0, 0, 0, 1, 0, 33'd2, 1, 1, 0);
`endif
        vt[5] = mk("strict_greater", 4, 32'd5, 32'd0, 6, 32'd0, -32'sd6, 15, 1, 6, 33'd6, 16, 0, 0);
        vt[7] = mk("full_scale", 8, 32'h8000_0000, 32'h8000_0000, -1, 0, 0, 15, 1, 8, 33'h1_0000_0000, 16, 0, 0);

        bus.s_axis_data_tdata = '0; bus.s_axis_data_tvalid = 1'b0;
        bus.s_axis_data_tlast = 1'b0; bus.peak_tready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst tready",      64'(bus.s_axis_data_tready), 64'd0);
        chk("rst peak_tvalid", 64'(bus.peak_tvalid), 64'd0);
        chk("rst peak_index",  64'(bus.peak_index),  64'd0);
        chk("rst peak_mag",    64'(bus.peak_mag),    64'd0);
        chk("rst frame_count", 64'(bus.frame_count), 64'd0);
        chk("rst events", 64'({bus.event_tlast_unexpected, bus.event_tlast_missing}), 64'd0);
        areset = 1'b0;
        #1;
        chk("release tready", 64'(bus.s_axis_data_tready), 64'd1);

        foreach (vt[i]) run_vec(vt[i]);

        // Result stall: beats offered during REPORT (even with tlast) must be dropped.
        send(vt[0]);
        bus.s_axis_data_tdata = {32'd0, 32'd9999}; bus.s_axis_data_tvalid = 1'b1;
        bus.s_axis_data_tlast = 1'b1;
        for (int c = 0; c < 20; c++) begin
            chk("stall tready",      64'(bus.s_axis_data_tready), 64'd0);
            chk("stall peak_tvalid", 64'(bus.peak_tvalid), 64'd1);
            chk("stall peak_index",  64'(bus.peak_index),  64'd5);
            chk("stall peak_mag",    64'(bus.peak_mag),    64'd150);
            chk("stall frame_count", 64'(bus.frame_count), 64'd16);
            @(posedge aclk);
            #1;
        end
        bus.s_axis_data_tvalid = 1'b0; bus.s_axis_data_tlast = 1'b0;
        bus.peak_tready = 1'b1;
        @(posedge aclk);
        #1;
        bus.peak_tready = 1'b0;
        chk("stall resume tready", 64'(bus.s_axis_data_tready), 64'd1);
        run_vec(vt[1]);

        // Reset mid-frame: partial frame with a large bin must leave no trace.
        for (int b = 0; b < 6; b++) beat((b == 2) ? 32'd1000 : 32'd0, 32'd0, 1'b0);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        chk("midrst tready", 64'(bus.s_axis_data_tready), 64'd0);
        areset = 1'b0;
        saw = 0;
        repeat (5) begin
            if (bus.peak_tvalid) saw = 1;
            @(posedge aclk);
            #1;
        end
        chk("midrst no peak", 64'(saw), 64'd0);
        run_vec(vt[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
